lp805x_sfr_pbuf: RTL
====================

Name: lp805x_sfr_pbuf

Overview:
Peripheral-side staging buffer that feeds the SFR synchronisation controller.
- Peripheral pushes data bytes (status snapshots, received data) into a small FIFO.
- The block stages one entry at a time into an output register and offers it to the controller with the sfr_prrdy / sfr_pget / sfr_pwrdy / sfr_pput handshake.
- Sits in the peripheral clock domain, directly upstream of the synchroniser.

Parameters:
DW, 8, data width of each entry and of sfr_pdata
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 2, pointer width, log2(DEPTH)

Ports:
clk  in  1  peripheral clock; only clock of the block
rst  in  1  reset; synchronous, active-low (0 = reset)
p_we  in  1  peripheral write strobe, one entry per cycle
p_data  in  DW  peripheral write data
p_full  out  1  FIFO full (registered count == DEPTH)
p_count  out  AW+1  current FIFO occupancy
sfr_pget  in  1  controller armed / consumer waiting (level)
sfr_pput  in  1  controller consumed staged entry (1-cycle pulse)
sfr_prrdy  out  1  new entry staged (1-cycle pulse)
sfr_pwrdy  out  1  staged entry stable and consumer armed (level)
sfr_pdata  out  DW  staged entry
ovf  out  1  sticky overflow flag (optional feature only)
ovf_clr  in  1  clears ovf (optional feature only)

Behaviour:
- Reset (rst=0 at posedge): FIFO emptied, pointers 0, p_count=0, p_full=0, sfr_prrdy=0, sfr_pwrdy=0, sfr_pdata=0, ovf=0, state=IDLE. Reset mid-handshake discards the staged entry and all FIFO contents.
- FIFO: circular with wrapping AW-bit pointers and AW+1-bit count.
  - p_we with count<DEPTH: write at wr_ptr.
  - p_we when full and no pop in the same cycle: write dropped, contents unchanged.
  - p_we and pop in the same cycle while full: both take effect, count unchanged.
- FSM states: IDLE, OFFER, ARMED. All outputs are registered.
  - IDLE: if count!=0, pop head into sfr_pdata, set sfr_prrdy=1, go to OFFER. Otherwise stay.
  - OFFER: sfr_prrdy=0, go to ARMED. Lasts one cycle, so sfr_prrdy is always an exact 1-cycle pulse.
  - ARMED: sfr_pwrdy <= sfr_pget each cycle. On sfr_pput=1, set sfr_pwrdy=0 and go to IDLE.
- sfr_pdata holds its value from pop until the next pop. It never changes while in OFFER or ARMED.
- sfr_pput outside ARMED is ignored.
- sfr_pput and p_we in the same cycle: write accepted; the new entry is staged on a later IDLE pass.
- Latency: p_we at edge N into an empty FIFO in IDLE gives count=1 after N, and sfr_prrdy high with sfr_pdata valid for edge N+1 to N+2.
- Back-to-back entries: minimum 3 cycles per entry (IDLE, OFFER, ARMED), plus the controller's round trip.

Optional Feature:
LP805X_SFRBUF_OVF_EN
- Defined:
  - ovf is set on any dropped write.
  - ovf_clr=1 clears it.
  - Same-cycle drop and ovf_clr: set wins, ovf=1.
- Undefined: ovf is tied to 0, ovf_clr is unused, and drops are silent.

Decomposition:
- Shared package lp805x_sfr_pkg holds:
  - FSM state encodings (IDLE=2'd0, OFFER=2'd1, ARMED=2'd2)
  - default DW/DEPTH constants
- One sub-module: lp805x_sfr_fifo (storage, pointers, count, full).
- The handshake FSM and staging register stay in the top module.

Test Plan:
- Reset with rst=0 for 2 cycles, release -> all outputs 0, p_count=0, state IDLE; a random sfr_pput has no effect.
- Single write p_data=8'hA5 at edge N -> sfr_prrdy=1 exactly for N+1..N+2 with sfr_pdata=8'hA5; drive sfr_pget=1 from N+2 -> sfr_pwrdy=1 from N+3; pulse sfr_pput -> sfr_pwrdy=0 next edge, p_count=0.
- Write 8'h01..8'h04 back-to-back with sfr_pget held low -> 8'h01 staged, p_count=3, sfr_pwrdy stays 0 indefinitely; then complete 4 handshakes -> sfr_pdata sequence 01,02,03,04 in order.
- Fill to DEPTH with the consumer stalled, write 8'hFF -> write dropped, p_full=1; with LP805X_SFRBUF_OVF_EN, ovf=1 until ovf_clr, and ovf_clr in the same cycle as a new drop leaves ovf=1.
- Full FIFO, p_we coincident with a pop in IDLE -> count stays DEPTH, new entry retained and delivered last; pointer wrap verified over 3*DEPTH entries.
- Assert rst=0 while in ARMED with sfr_pwrdy=1 and 3 entries queued -> next cycle all outputs 0, p_count=0; later writes are delivered normally.

Source files
------------

// File: rtl/lp805x_sfr_pbuf_pkg.sv
// lp805x_sfr_pkg: shared definitions for the peripheral-side SFR staging buffer.
//   sfr_state_t   - handshake FSM state encoding (IDLE/OFFER/ARMED)
//   SFR_DW_DEF    - default entry width
//   SFR_DEPTH_DEF - default FIFO depth (power of two, >= 2)
package lp805x_sfr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_ARMED = 2'd2
  } sfr_state_t;

  localparam int SFR_DW_DEF    = 8;
  localparam int SFR_DEPTH_DEF = 4;

endpackage

// File: rtl/lp805x_sfr_pbuf_if.sv
// lp805x_sfr_pbuf_if: handshake bundle between the staging buffer and the
// SFR synchronisation controller.
//
// Handshake semantics:
//   sfr_prrdy - buffer -> controller, 1-cycle pulse: a new entry has just
//               been loaded into sfr_pdata.
//   sfr_pget  - controller -> buffer, level: the consumer is armed/waiting.
//   sfr_pwrdy - buffer -> controller, level: the staged entry is stable and
//               the consumer is armed (registered copy of sfr_pget in ARMED).
//   sfr_pput  - controller -> buffer, 1-cycle pulse: staged entry consumed.
//               Honoured only in ARMED; ignored elsewhere.
//   sfr_pdata - staged entry; constant from one pop until the next pop.
//
// Modports: master = staging buffer, slave = controller.
interface lp805x_sfr_pbuf_if #(
  parameter int DW = 8
);
  logic          sfr_pget;
  logic          sfr_pput;
  logic          sfr_prrdy;
  logic          sfr_pwrdy;
  logic [DW-1:0] sfr_pdata;

  modport master (
    input  sfr_pget,
    input  sfr_pput,
    output sfr_prrdy,
    output sfr_pwrdy,
    output sfr_pdata
  );

  modport slave (
    output sfr_pget,
    output sfr_pput,
    input  sfr_prrdy,
    input  sfr_pwrdy,
    input  sfr_pdata
  );
endinterface

// File: rtl/lp805x_sfr_pbuf_fifo.sv
// lp805x_sfr_fifo: circular FIFO storage for the SFR staging buffer.
// Ports:
//   clk, rst  - clock, synchronous active-low reset (empties the FIFO)
//   we, wdata - write strobe / data (one entry per cycle)
//   pop       - remove the head entry (ignored when empty)
//   head      - current head entry (valid when count != 0)
//   count     - occupancy, AW+1 bits
//   full      - count == DEPTH
//   drop      - this cycle's write is being discarded (full, no pop)
module lp805x_sfr_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          drop
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == FULL_CNT);
  assign rd_ok = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // still accepted and the count stays at DEPTH.
  assign wr_ok = we && (!full || rd_ok);
  assign drop  = we && full && !rd_ok;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lp805x_sfr_pbuf.sv
// lp805x_sfr_pbuf: peripheral-side staging buffer feeding the SFR
// synchronisation controller. The peripheral pushes bytes into a small FIFO;
// a three-state FSM stages one entry at a time into sfr_pdata and offers it
// through the sfr_prrdy / sfr_pget / sfr_pwrdy / sfr_pput handshake.
//
// Ports:
//   clk, rst   - peripheral clock, synchronous active-low reset
//   p_we       - peripheral write strobe
//   p_data     - peripheral write data
//   p_full     - FIFO full
//   p_count    - FIFO occupancy (excludes the staged entry)
//   ovf        - sticky overflow flag (LP805X_SFRBUF_OVF_EN only, else 0)
//   ovf_clr    - clears ovf (LP805X_SFRBUF_OVF_EN only, else unused)
//   dbg_state  - current FSM state
//   sfr        - handshake bundle, master side
//
// Build option: define LP805X_SFRBUF_OVF_EN to enable the overflow flag.
module lp805x_sfr_pbuf
  import lp805x_sfr_pkg::*;
#(
  parameter int DW    = SFR_DW_DEF,
  parameter int DEPTH = SFR_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_we,
  input  logic [DW-1:0]            p_data,
  output logic                     p_full,
  output logic [AW:0]              p_count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output sfr_state_t               dbg_state,
  lp805x_sfr_pbuf_if.master        sfr
);

  sfr_state_t    state, state_n;
  logic          prrdy_q, prrdy_n;
  logic          pwrdy_q, pwrdy_n;
  logic [DW-1:0] pdata_q, pdata_n;
  logic          pop;
  logic [DW-1:0] head;
  logic          drop;

  lp805x_sfr_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (p_we),
    .wdata (p_data),
    .pop   (pop),
    .head  (head),
    .count (p_count),
    .full  (p_full),
    .drop  (drop)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      prrdy_q <= 1'b0;
      pwrdy_q <= 1'b0;
      pdata_q <= '0;
    end else begin
      state   <= state_n;
      prrdy_q <= prrdy_n;
      pwrdy_q <= pwrdy_n;
      pdata_q <= pdata_n;
    end
  end

  always_comb begin
    state_n = state;
    prrdy_n = 1'b0;
    pwrdy_n = 1'b0;
    pdata_n = pdata_q;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (p_count != '0) begin
          pop     = 1'b1;
          pdata_n = head;
          prrdy_n = 1'b1;
          state_n = ST_OFFER;
        end
      end
      // One-cycle state so sfr_prrdy is always exactly one cycle wide.
      ST_OFFER: begin
        state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (sfr.sfr_pput) begin
          state_n = ST_IDLE;
        end else begin
          pwrdy_n = sfr.sfr_pget;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign sfr.sfr_prrdy = prrdy_q;
  assign sfr.sfr_pwrdy = pwrdy_q;
  assign sfr.sfr_pdata = pdata_q;
  assign dbg_state     = state;

`ifdef LP805X_SFRBUF_OVF_EN
  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_sigs;
  assign unused_ovf_sigs = ^{ovf_clr, drop};
  assign ovf = 1'b0;
`endif

endmodule
